// File: rtl/ppl_block_arb.sv
// Round-robin arbiter sharing one world block RAM read port between LANES ray-march lanes.
// Optional macro PPL_BLOCK_ARB_STAT_EN adds the stall_cnt statistics output.
module ppl_block_arb #(
    parameter int LANES   = 4,
    parameter int RAM_LAT = 2,
    parameter int ADDR_W  = 15,
    parameter int ID_W    = 5
) (
    input  logic                    clk_ppl,
    input  logic                    rst,
    input  logic                    frame_flush,
    input  logic [LANES-1:0]        req,
    input  logic [LANES*ADDR_W-1:0] req_addr,
    output logic [LANES-1:0]        gnt,
    output logic                    ram_en,
    output logic [ADDR_W-1:0]       ram_addr,
    input  logic [ID_W-1:0]         ram_dout,
    output logic [LANES-1:0]        rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
`ifdef PPL_BLOCK_ARB_STAT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]   r_pending;
    logic [IDX_W-1:0]   r_rr;
    logic [RAM_LAT-1:0] r_tag_vld;
    logic [IDX_W-1:0]   r_tag_idx [RAM_LAT];
    logic [LANES-1:0]   r_gnt;
    logic               r_ram_en;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [LANES-1:0]   r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;

    logic [LANES-1:0]   w_eligible;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_rr_next;
    logic [LANES-1:0]   w_gnt_onehot;
    logic [LANES-1:0]   w_rsp_onehot;

    // NOTE: eligibility uses the pre-edge pending bits, so a lane whose response
    // retires this edge cannot be re-granted until the following edge.
    always_comb begin
        w_eligible = req & ~r_pending;
        w_found    = 1'b0;
        w_win      = '0;
        // Descending scan: the last hit written is the one nearest to r_rr.
        for (int k = LANES - 1; k >= 0; k--) begin
            if (w_eligible[(int'(r_rr) + k) % LANES]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_rr) + k) % LANES);
            end
        end
        w_rr_next    = (int'(w_win) == LANES - 1) ? '0 : w_win + 1'b1;
        w_gnt_onehot = w_found ? (LANES'(1) << w_win) : '0;
        w_rsp_onehot = r_tag_vld[RAM_LAT-1] ? (LANES'(1) << r_tag_idx[RAM_LAT-1]) : '0;
    end

    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_rr        <= '0;
            r_tag_vld   <= '0;
            for (int k = 0; k < RAM_LAT; k++) r_tag_idx[k] <= '0;
            r_gnt       <= '0;
            r_ram_en    <= 1'b0;
            r_ram_addr  <= '0;
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
        end else if (frame_flush) begin
            // In-flight RAM data still arrives but its tags are gone, so it is never reported.
            r_pending   <= '0;
            r_rr        <= '0;
            r_tag_vld   <= '0;
            r_gnt       <= '0;
            r_ram_en    <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            r_gnt     <= w_gnt_onehot;
            r_ram_en  <= w_found;
            if (w_found) begin
                r_ram_addr <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                r_rr       <= w_rr_next;
            end
            r_tag_vld[0] <= w_found;
            r_tag_idx[0] <= w_win;
            for (int k = 1; k < RAM_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
            r_rsp_valid <= w_rsp_onehot;
            if (r_tag_vld[RAM_LAT-1]) begin
                r_rsp_id <= ram_dout;
            end
            r_pending <= (r_pending & ~w_rsp_onehot) | w_gnt_onehot;
        end
    end

`ifdef PPL_BLOCK_ARB_STAT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_ppl or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (frame_flush) begin
            r_stall_cnt <= '0;
        end else if (|req && !w_found && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign gnt       = r_gnt;
    assign ram_en    = r_ram_en;
    assign ram_addr  = r_ram_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign busy      = |r_pending;

endmodule
